// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg
//   Shared definitions for the PIO command queue:
//   - dispatch FSM state encoding
//   - bit positions inside the 8-bit status word
//   - default parameter values
package pio_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Status word layout: {overflow, timeout, count[5:0]}
  localparam int STAT_OVF  = 7;
  localparam int STAT_TMO  = 6;
  localparam int COUNT_LSB = 0;
  localparam int COUNT_W   = 6;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 0;

endpackage

// File: rtl/pio_cmd_fifo.sv
// pio_cmd_fifo
//   Synchronous show-ahead FIFO, DEPTH x W. The head entry is always
//   visible on rdata while the FIFO is not empty; pop advances to the next.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     push, wdata  : write wdata when push is high and the FIFO is not full
//     pop, rdata   : rdata is the head; pop discards it (ignored when empty)
//     count        : number of stored entries (0..DEPTH)
//     full, empty  : derived from count
module pio_cmd_fifo
  import pio_cmd_pkg::*;
#(
  parameter int W     = DEF_INSTR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pio_cmd_queue.sv
// pio_cmd_queue
//   Command front end between the HPS PIO ports and the image coprocessor.
//   Software pushes instruction words with a four-phase start/donewrite
//   handshake; words are queued and dispatched one at a time to the
//   coprocessor, each dispatch waiting for cop_done (or a watchdog expiry).
//   Ports:
//     clk_clk, reset_reset_n : clock, asynchronous active-low reset
//     pio_instruct           : instruction word from the HPS
//     pio_start              : request level; rising edge requests a push
//     pio_clear              : level; clears sticky overflow/timeout flags
//     pio_donewrite          : push acknowledge
//     pio_done               : queue drained and engine idle
//     pio_status             : {overflow, timeout, count[5:0]}, registered
//     cop_instr, cop_valid   : instruction offered to the coprocessor
//     cop_ready              : coprocessor accepts cop_instr
//     cop_done               : one-cycle completion pulse
//     dbg_state              : current dispatch FSM state
//   Coprocessor handshake: a transfer occurs on a clock edge where cop_valid
//   and cop_ready are both high; once cop_valid is raised, cop_instr and
//   cop_valid stay stable until that transfer, and cop_valid drops the cycle
//   after it.
module pio_cmd_queue
  import pio_cmd_pkg::*;
#(
  parameter int INSTR_W        = DEF_INSTR_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [INSTR_W-1:0] pio_instruct,
  input  logic               pio_start,
  input  logic               pio_clear,
  output logic               pio_donewrite,
  output logic               pio_done,
  output logic [7:0]         pio_status,
  output logic [INSTR_W-1:0] cop_instr,
  output logic               cop_valid,
  input  logic               cop_ready,
  input  logic               cop_done,
  output state_t             dbg_state
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t             state_q, state_d;
  logic               start_q;
  logic               push_req;
  logic               push_acc;
  logic               pop;
  logic               tmo_set;
  logic               ovf_set;
  logic               ovf_q, tmo_q;
  logic               ovf_d, tmo_d;
  logic               pending_q;
  logic [TMR_W-1:0]   timer_q;
  logic [INSTR_W-1:0] fifo_rdata;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      count_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wd_hit;

  assign dbg_state = state_q;

  // Full test uses the current count: a same-cycle pop cannot rescue a push.
  assign push_req = pio_start & ~start_q;
  assign push_acc = push_req & ~fifo_full;
  assign ovf_set  = push_req & fifo_full;

  pio_cmd_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push_acc),
    .pop   (pop),
    .wdata (pio_instruct),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  // Dispatch FSM next-state logic.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cop_valid && cop_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (cop_done) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a set event wins over a coincident clear.
  always_comb begin
    ovf_d = ovf_set ? 1'b1 : (pio_clear ? 1'b0 : ovf_q);
    tmo_d = tmo_set ? 1'b1 : (pio_clear ? 1'b0 : tmo_q);
  end

  assign count_d = fifo_count + CW'(push_acc) - CW'(pop);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      pio_donewrite <= 1'b0;
      pio_done      <= 1'b0;
      pending_q     <= 1'b0;
      pio_status    <= '0;
      cop_instr     <= '0;
      cop_valid     <= 1'b0;
      timer_q       <= '0;
      ovf_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= pio_start;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;

      // Acknowledge accepted and dropped requests alike, so software
      // never stalls on overflow; release once start is seen low.
      if (push_req)        pio_donewrite <= 1'b1;
      else if (!pio_start) pio_donewrite <= 1'b0;

      // pending_q remembers that work arrived since the last done report.
      if (push_acc) begin
        pio_done  <= 1'b0;
        pending_q <= 1'b1;
      end else if (state_q == IDLE && fifo_empty && pending_q) begin
        pio_done  <= 1'b1;
        pending_q <= 1'b0;
      end

      if (pop) begin
        cop_instr <= fifo_rdata;
        cop_valid <= 1'b1;
      end else if (state_q == ISSUE && cop_ready) begin
        cop_valid <= 1'b0;
      end

      if (state_q == ISSUE)          timer_q <= '0;
      else if (state_q == WAIT_DONE) timer_q <= timer_q + 1'b1;

      pio_status <= {ovf_d, tmo_d, COUNT_W'(count_d)};
    end
  end

endmodule

// File: tb/tb_pio_cmd_queue.sv
// tb_pio_cmd_queue
//   Directed bench for pio_cmd_queue (DEPTH 8, watchdog 16 cycles).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pio_cmd_queue;
  import pio_cmd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pio_instruct;
  logic        pio_start;
  logic        pio_clear;
  logic        pio_donewrite;
  logic        pio_done;
  logic [7:0]  pio_status;
  logic [31:0] cop_instr;
  logic        cop_valid;
  logic        cop_ready;
  logic        cop_done;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  pio_cmd_queue #(
    .INSTR_W        (32),
    .DEPTH          (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pio_instruct  (pio_instruct),
    .pio_start     (pio_start),
    .pio_clear     (pio_clear),
    .pio_donewrite (pio_donewrite),
    .pio_done      (pio_done),
    .pio_status    (pio_status),
    .cop_instr     (cop_instr),
    .cop_valid     (cop_valid),
    .cop_ready     (cop_ready),
    .cop_done      (cop_done),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Four-phase push: raise start, see donewrite, drop start, see it fall.
  task automatic push_word(input logic [31:0] w);
    pio_instruct = w;
    pio_start    = 1'b1;
    tick();
    check("donewrite_rise", 32'(pio_donewrite), 32'h1);
    pio_start = 1'b0;
    tick();
    check("donewrite_fall", 32'(pio_donewrite), 32'h0);
  endtask

  // Accept one issued word, compare against the scoreboard, finish it
  // with a cop_done pulse five cycles after the handshake.
  task automatic serve_one();
    int          waited;
    logic [31:0] exp;
    waited = 0;
    while (cop_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("issue_wait", 32'(cop_valid), 32'h1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else                   exp = 32'hDEAD_BEEF;
    check("issue_order", cop_instr, exp);
    cop_ready = 1'b1;
    tick();
    check("valid_drop", 32'(cop_valid), 32'h0);
    cop_ready = 1'b0;
    ticks(4);
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n        = 1'b0;
    pio_instruct = '0;
    pio_start    = 1'b0;
    pio_clear    = 1'b0;
    cop_ready    = 1'b0;
    cop_done     = 1'b0;
    ticks(2);
    check("rst_donewrite", 32'(pio_donewrite), 32'h0);
    check("rst_done", 32'(pio_done), 32'h0);
    check("rst_status", 32'(pio_status), 32'h0);
    check("rst_valid", 32'(cop_valid), 32'h0);
    rst_n = 1'b1;
    ticks(2);

    // Single command with latency checks
    pio_instruct = 32'h0000_00A5;
    pio_start    = 1'b1;
    tick();
    check("single_donewrite", 32'(pio_donewrite), 32'h1);
    check("single_valid_early", 32'(cop_valid), 32'h0);
    pio_start = 1'b0;
    tick();
    check("single_valid", 32'(cop_valid), 32'h1);
    check("single_instr", cop_instr, 32'hA5);
    check("single_dw_fall", 32'(pio_donewrite), 32'h0);
    cop_ready = 1'b1;
    tick();
    cop_ready = 1'b0;
    check("single_wait", 32'(dbg_state), 32'(WAIT_DONE));
    ticks(4);
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    check("single_idle", 32'(dbg_state), 32'(IDLE));
    check("single_done_early", 32'(pio_done), 32'h0);
    tick();
    check("single_done", 32'(pio_done), 32'h1);
    check("single_status", 32'(pio_status), 32'h00);

    // Burst of 8 with the coprocessor stalled, then drain in order
    for (int i = 1; i <= 8; i++) begin
      push_word(32'(i));
      exp_q.push_back(32'(i));
    end
    tick();
    check("burst_count", 32'(pio_status), 32'h07);
    check("burst_done_low", 32'(pio_done), 32'h0);
    for (int k = 0; k < 8; k++) begin
      serve_one();
      tick();
      check("burst_done", 32'(pio_done), (k == 7) ? 32'h1 : 32'h0);
    end

    // Overflow: 9 accepted (8 queued + 1 in ISSUE), 10th dropped with a
    // coincident clear that must lose to the set
    for (int i = 0; i < 9; i++) begin
      push_word(32'h11 + 32'(i));
      exp_q.push_back(32'h11 + 32'(i));
    end
    check("full_no_ovf", 32'(pio_status), 32'h08);
    pio_instruct = 32'h1A;
    pio_start    = 1'b1;
    pio_clear    = 1'b1;
    tick();
    pio_clear = 1'b0;
    check("ovf_vs_clear", 32'(pio_status), 32'h88);
    check("ovf_donewrite", 32'(pio_donewrite), 32'h1);
    pio_start = 1'b0;
    tick();
    check("ovf_dw_fall", 32'(pio_donewrite), 32'h0);
    check("ovf_sticky", 32'(pio_status), 32'h88);
    pio_clear = 1'b1;
    tick();
    pio_clear = 1'b0;
    check("ovf_cleared", 32'(pio_status), 32'h08);
    for (int k = 0; k < 9; k++) serve_one();
    tick();
    check("ovf_done", 32'(pio_done), 32'h1);
    check("ovf_status_empty", 32'(pio_status), 32'h00);
    ticks(3);
    check("ovf_word10_lost", 32'(cop_valid), 32'h0);

    // Push coinciding with a pop at count 3
    for (int i = 0; i < 4; i++) begin
      push_word(32'h21 + 32'(i));
      exp_q.push_back(32'h21 + 32'(i));
    end
    check("pp_count_before", 32'(pio_status), 32'h03);
    check("pp_first", cop_instr, exp_q.pop_front());
    cop_ready = 1'b1;
    tick();
    cop_ready = 1'b0;
    ticks(4);
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    exp_q.push_back(32'h25);
    pio_instruct = 32'h25;
    pio_start    = 1'b1;
    tick();
    check("pp_count_same", 32'(pio_status), 32'h03);
    check("pp_valid", 32'(cop_valid), 32'h1);
    check("pp_donewrite", 32'(pio_donewrite), 32'h1);
    pio_start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) serve_one();
    tick();
    check("pp_done", 32'(pio_done), 32'h1);

    // Watchdog: no cop_done after the handshake
    push_word(32'h31);
    push_word(32'h32);
    check("wd_count", 32'(pio_status), 32'h01);
    cop_ready = 1'b1;
    tick();
    cop_ready = 1'b0;
    check("wd_wait_state", 32'(dbg_state), 32'(WAIT_DONE));
    ticks(15);
    check("wd_not_yet", 32'(pio_status), 32'h01);
    tick();
    check("wd_timeout", 32'(pio_status), 32'h41);
    check("wd_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    check("wd_next_valid", 32'(cop_valid), 32'h1);
    check("wd_next_instr", cop_instr, 32'h32);
    check("wd_status_pop", 32'(pio_status), 32'h40);
    exp_q.push_back(32'h32);
    serve_one();
    tick();
    check("wd_done", 32'(pio_done), 32'h1);
    pio_clear = 1'b1;
    tick();
    pio_clear = 1'b0;
    check("wd_cleared", 32'(pio_status), 32'h00);

    // Reset during WAIT_DONE with 4 queued
    for (int i = 0; i < 4; i++) push_word(32'h41 + 32'(i));
    cop_ready = 1'b1;
    tick();
    cop_ready    = 1'b0;
    pio_instruct = 32'h45;
    pio_start    = 1'b1;
    tick();
    check("mid_status", 32'(pio_status), 32'h04);
    check("mid_dw", 32'(pio_donewrite), 32'h1);
    check("mid_state", 32'(dbg_state), 32'(WAIT_DONE));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(cop_valid), 32'h0);
    check("arst_done", 32'(pio_done), 32'h0);
    check("arst_dw", 32'(pio_donewrite), 32'h0);
    check("arst_status", 32'(pio_status), 32'h0);
    check("arst_instr", cop_instr, 32'h0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    pio_start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cop_valid === 1'b1) seen = 1;
    end
    check("no_stale_issue", 32'(seen), 32'h0);
    check("post_rst_status", 32'(pio_status), 32'h0);
    check("post_rst_done", 32'(pio_done), 32'h0);
    exp_q.delete();
    exp_q.push_back(32'h55);
    push_word(32'h55);
    serve_one();
    tick();
    check("post_rst_work", 32'(pio_done), 32'h1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
